// File: rtl/vga_window_scaler.sv
`timescale 1ns/1ps
// vga_window_scaler
// Generates the VGA raster counters and places a WIN_W x WIN_H window, at a
// per-frame origin, inside the active area. Window content is upscaled x1/x2/x4
// by nearest-neighbour replication. Replicated lines are replayed from an
// internal line buffer, so each source pixel is read from the FIFO once per frame.
// Ports:
//   i_clk, i_rst            pixel clock, asynchronous active-high reset
//   i_enable, i_scale       window enable and scale select (latched at frame start)
//   i_win_x, i_win_y        window origin within the active area (latched, clamped)
//   i_Red/i_Green/i_Blue    source pixel, valid one cycle after o_read_request
//   o_read_request          FIFO read strobe
//   o_Red/o_Green/o_Blue    output pixel, zero outside the window
//   o_de                    active-video flag aligned with RGB
//   o_frame_start           pulse at h_cnt = 0, v_cnt = 0
module vga_window_scaler #(
  parameter int unsigned COLOR_W      = 10,
  parameter int unsigned H_SYNC_CYC   = 128,
  parameter int unsigned H_SYNC_BACK  = 88,
  parameter int unsigned H_SYNC_ACT   = 800,
  parameter int unsigned H_SYNC_TOTAL = 1056,
  parameter int unsigned V_SYNC_CYC   = 4,
  parameter int unsigned V_SYNC_BACK  = 23,
  parameter int unsigned V_SYNC_ACT   = 600,
  parameter int unsigned V_SYNC_TOTAL = 628,
  parameter int unsigned WIN_W        = 384,
  parameter int unsigned WIN_H        = 384
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic [1:0]         i_scale,
  input  logic [10:0]        i_win_x,
  input  logic [9:0]         i_win_y,
  input  logic [COLOR_W-1:0] i_Red,
  input  logic [COLOR_W-1:0] i_Green,
  input  logic [COLOR_W-1:0] i_Blue,
  output logic               o_read_request,
  output logic [COLOR_W-1:0] o_Red,
  output logic [COLOR_W-1:0] o_Green,
  output logic [COLOR_W-1:0] o_Blue,
  output logic               o_de,
  output logic               o_frame_start
);

  localparam int unsigned CNT_W    = 13;
  localparam int unsigned PIX_W    = 3 * COLOR_W;
  localparam int unsigned LB_DEPTH = WIN_W / 2;
  localparam int unsigned LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  localparam logic [CNT_W-1:0] X_START = CNT_W'(H_SYNC_CYC + H_SYNC_BACK);
  localparam logic [CNT_W-1:0] X_END   = CNT_W'(H_SYNC_CYC + H_SYNC_BACK + H_SYNC_ACT);
  localparam logic [CNT_W-1:0] Y_START = CNT_W'(V_SYNC_CYC + V_SYNC_BACK);
  localparam logic [CNT_W-1:0] Y_END   = CNT_W'(V_SYNC_CYC + V_SYNC_BACK + V_SYNC_ACT);
  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_SYNC_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_SYNC_TOTAL - 1);
  localparam logic [CNT_W-1:0] WX_MAX  = CNT_W'(H_SYNC_ACT - WIN_W);
  localparam logic [CNT_W-1:0] WY_MAX  = CNT_W'(V_SYNC_ACT - WIN_H);
  localparam logic [CNT_W-1:0] WIN_W_C = CNT_W'(WIN_W);
  localparam logic [CNT_W-1:0] WIN_H_C = CNT_W'(WIN_H);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             lat_en;
  logic [1:0]       lat_sh;
  logic [CNT_W-1:0] lat_wx, lat_wy;

  logic [CNT_W-1:0] win_x_c, win_y_c, h_ahead, x_lo, y_lo, ox, oy, mask;
  logic [1:0]       sh_c;
  logic             frame_start_c, in_win_c, fetch_line_c, col_first_c;

  logic             b_win, b_fetch, b_first;
  logic [LB_AW-1:0] b_sx;
  logic             c_win, c_fetch, c_first;
  logic [LB_AW-1:0] c_sx;

  logic [PIX_W-1:0] pix_in, pix_q, lb_rdata;
  logic             lb_we;
  logic [PIX_W-1:0] lb_mem [LB_DEPTH];

  assign pix_in                    = {i_Red, i_Green, i_Blue};
  assign {o_Red, o_Green, o_Blue}  = pix_q;
  assign frame_start_c             = (h_cnt == '0) && (v_cnt == '0);
  assign lb_we                     = c_win && c_fetch && c_first && (lat_sh != 2'd0);

  // Raster counters
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + CNT_W'(1);
    end
  end

  // Clamp origin, decode scale, and evaluate the window two pixels ahead
  always_comb begin
    win_x_c = CNT_W'(i_win_x);
    if (win_x_c > WX_MAX) win_x_c = WX_MAX;
    win_y_c = CNT_W'(i_win_y);
    if (win_y_c > WY_MAX) win_y_c = WY_MAX;
    sh_c = (i_scale == 2'd0) ? 2'd0 : ((i_scale == 2'd1) ? 2'd1 : 2'd2);

    h_ahead      = h_cnt + CNT_W'(2);
    x_lo         = X_START + lat_wx;
    y_lo         = Y_START + lat_wy;
    ox           = h_ahead - x_lo;
    oy           = v_cnt - y_lo;
    mask         = (CNT_W'(1) << lat_sh) - CNT_W'(1);
    in_win_c     = lat_en && (h_ahead >= x_lo) && (ox < WIN_W_C) &&
                   (v_cnt >= y_lo) && (oy < WIN_H_C);
    fetch_line_c = (oy & mask) == '0;
    col_first_c  = (ox & mask) == '0;
  end

  // Per-frame configuration latch
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lat_en <= 1'b0;
      lat_sh <= 2'd0;
      lat_wx <= '0;
      lat_wy <= '0;
    end else if (frame_start_c) begin
      lat_en <= i_enable;
      lat_sh <= sh_c;
      lat_wx <= win_x_c;
      lat_wy <= win_y_c;
    end
  end

  // Pipeline: request / line-buffer read at H-1, data capture at H, RGB at H+1
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_read_request <= 1'b0;
      o_de           <= 1'b0;
      o_frame_start  <= 1'b0;
      b_win          <= 1'b0;
      b_fetch        <= 1'b0;
      b_first        <= 1'b0;
      b_sx           <= '0;
      c_win          <= 1'b0;
      c_fetch        <= 1'b0;
      c_first        <= 1'b0;
      c_sx           <= '0;
      pix_q          <= '0;
    end else begin
      o_read_request <= in_win_c && fetch_line_c && col_first_c;
      o_de           <= (h_cnt >= X_START) && (h_cnt < X_END) &&
                        (v_cnt >= Y_START) && (v_cnt < Y_END);
      o_frame_start  <= (h_cnt == H_LAST) && (v_cnt == V_LAST);
      b_win          <= in_win_c;
      b_fetch        <= fetch_line_c;
      b_first        <= col_first_c;
      b_sx           <= LB_AW'(ox >> lat_sh);
      c_win          <= b_win;
      c_fetch        <= b_fetch;
      c_first        <= b_first;
      c_sx           <= b_sx;
      // Non-first columns of a group keep the pixel already on the output
      if (!c_win)        pix_q <= '0;
      else if (!c_fetch) pix_q <= lb_rdata;
      else if (c_first)  pix_q <= pix_in;
    end
  end

  // Line buffer: written on fetch lines, read one cycle ahead on replay lines
  always_ff @(posedge i_clk) begin
    if (lb_we) lb_mem[c_sx] <= pix_in;
    if (b_win && !b_fetch) lb_rdata <= lb_mem[b_sx];
  end

endmodule

// File: tb/tb_vga_window_scaler.sv
`timescale 1ns/1ps
// Self-checking bench for vga_window_scaler using a reduced raster
// (48x22 total, 32x16 active, 16x8 window) so each frame is 1056 cycles.
module tb_vga_window_scaler;

  localparam int CW = 10;
  localparam int HC = 4, HB = 4, HA = 32, HT = 48;
  localparam int VC = 2, VB = 2, VA = 16, VT = 22;
  localparam int WW = 16, WH = 8;
  localparam int XS = HC + HB, YS = VC + VB, FRAME = HT * VT;

  logic          clk = 1'b0, rst = 1'b0, en = 1'b0;
  logic [1:0]    scale = 2'd0;
  logic [10:0]   win_x = '0;
  logic [9:0]    win_y = '0;
  logic [CW-1:0] r_in = '0, g_in = '0, b_in = '0;
  logic          req, de, fs;
  logic [CW-1:0] r_out, g_out, b_out;

  int checks = 0, errors = 0;
  int th = 0, tv = 0, fidx = 0;
  bit e_en;
  int e_sh, e_wx, e_wy;
  int cap_reads, cap_frv, cap_frh, cap_fgv, cap_fgh, cap_lgh;
  int cap_img, cap_de, cap_fs, cap_ph, cap_decnt, cap_eh, cap_ev;
  logic [29:0] cap_ea, cap_ee;

  vga_window_scaler #(
    .COLOR_W(CW), .H_SYNC_CYC(HC), .H_SYNC_BACK(HB), .H_SYNC_ACT(HA), .H_SYNC_TOTAL(HT),
    .V_SYNC_CYC(VC), .V_SYNC_BACK(VB), .V_SYNC_ACT(VA), .V_SYNC_TOTAL(VT),
    .WIN_W(WW), .WIN_H(WH)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_scale(scale),
    .i_win_x(win_x), .i_win_y(win_y),
    .i_Red(r_in), .i_Green(g_in), .i_Blue(b_in),
    .o_read_request(req), .o_Red(r_out), .o_Green(g_out), .o_Blue(b_out),
    .o_de(de), .o_frame_start(fs)
  );

  always #5 clk = ~clk;

  // Bench-side raster position (value of h_cnt/v_cnt during the current cycle)
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      th <= 0;
      tv <= 0;
    end else if (th == HT - 1) begin
      th <= 0;
      tv <= (tv == VT - 1) ? 0 : tv + 1;
    end else begin
      th <= th + 1;
    end
  end

  function automatic logic [29:0] pattern(int k);
    return {10'(k + 1), 10'(k * 3 + 5), 10'(1023 - k)};
  endfunction

  // Expected RGB for the pixel computed at h (visible at h+1) on line v
  function automatic logic [29:0] exp_pix(int h, int v);
    int ox, oy;
    if (!e_en) return '0;
    ox = h - XS - e_wx;
    oy = v - YS - e_wy;
    if (ox < 0 || ox >= WW || oy < 0 || oy >= WH) return '0;
    return pattern((oy >> e_sh) * (WW >> e_sh) + (ox >> e_sh));
  endfunction

  function automatic bit exp_de(int h, int v);
    return (h >= XS + 1) && (h < XS + HA + 1) && (v >= YS) && (v < YS + VA);
  endfunction

  // FIFO model: incrementing pattern, restarted each frame, data one cycle after request
  initial begin
    forever begin
      @(negedge clk);
      if (th == 0 && tv == 0) fidx = 0;
      if (req === 1'b1) begin
        @(posedge clk);
        #1;
        {r_in, g_in, b_in} = pattern(fidx);
        fidx++;
      end
    end
  end

  task automatic set_frame(input bit en_i, input logic [1:0] sc, input int wx, input int wy);
    en    = en_i;
    scale = sc;
    win_x = 11'(wx);
    win_y = 10'(wy);
    e_en  = en_i;
    e_sh  = (sc == 2'd0) ? 0 : ((sc == 2'd1) ? 1 : 2);
    e_wx  = (wx > HA - WW) ? HA - WW : wx;
    e_wy  = (wy > VA - WH) ? VA - WH : wy;
  endtask

  // Observe one full frame starting at the negedge of cycle (0,0)
  task automatic capture(input bit post_reset, input bit do_mid,
                         input logic [1:0] mid_sc, input int mid_wx);
    logic [29:0] act, expv;
    int m, ox, oy;
    cap_reads = 0; cap_frv = -1; cap_frh = -1; cap_fgv = -1; cap_fgh = -1; cap_lgh = -1;
    cap_img = 0; cap_de = 0; cap_fs = 0; cap_ph = 0; cap_decnt = 0;
    cap_eh = -1; cap_ev = -1; cap_ea = '0; cap_ee = '0;
    m = (1 << e_sh) - 1;
    for (int i = 0; i < FRAME; i++) begin
      if (do_mid && i == FRAME / 2) begin
        scale = mid_sc;
        win_x = 11'(mid_wx);
      end
      if (req === 1'b1) begin
        cap_reads++;
        if (cap_frv < 0) begin cap_frv = tv; cap_frh = th; end
        ox = th + 1 - XS - e_wx;
        oy = tv - YS - e_wy;
        if (!e_en || ox < 0 || ox >= WW || oy < 0 || oy >= WH || (ox & m) != 0 || (oy & m) != 0)
          cap_ph++;
      end
      act = {r_out, g_out, b_out};
      if (act != '0) begin
        if (cap_fgv < 0) begin cap_fgv = tv; cap_fgh = th; end
        cap_lgh = th;
      end
      expv = exp_pix(th - 1, tv);
      if (act !== expv) begin
        if (cap_img == 0) begin cap_eh = th; cap_ev = tv; cap_ea = act; cap_ee = expv; end
        cap_img++;
      end
      if (de !== exp_de(th, tv)) cap_de++;
      if (de === 1'b1) cap_decnt++;
      if (fs !== ((th == 0 && tv == 0 && !(post_reset && i == 0)) ? 1'b1 : 1'b0)) cap_fs++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    set_frame(1'b1, 2'd0, 4, 2);
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({req, de, fs} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: req/de/fs=%b want 000", {req, de, fs});
    end
    checks++;
    if ({r_out, g_out, b_out} !== 30'd0) begin
      errors++; $display("FAIL reset_rgb: rgb=%h want 0", {r_out, g_out, b_out});
    end
    rst = 1'b0;
  endtask

  task automatic test_scale1();
    int n;
    n = 0;
    while (!(th == 0 && tv == 0) && n < 2 * FRAME) begin @(negedge clk); n++; end
    checks++;
    if (n >= 2 * FRAME) begin errors++; $display("FAIL frame_wait: no frame start in %0d cycles", n); end
    capture(1'b1, 1'b0, 2'd0, 0);
    checks++;
    if (cap_frv != 6 || cap_frh != 11) begin
      errors++; $display("FAIL x1_first_req: v=%0d h=%0d want v=6 h=11", cap_frv, cap_frh);
    end
    checks++;
    if (cap_fgv != 6 || cap_fgh != 13) begin
      errors++; $display("FAIL x1_first_rgb: v=%0d h=%0d want v=6 h=13", cap_fgv, cap_fgh);
    end
    checks++;
    if (cap_reads != 128) begin errors++; $display("FAIL x1_reads: got %0d want 128", cap_reads); end
    checks++;
    if (cap_img != 0) begin
      errors++;
      $display("FAIL x1_image: %0d bad, first v=%0d h=%0d got %h want %h", cap_img, cap_ev, cap_eh, cap_ea, cap_ee);
    end
    checks++;
    if (cap_de != 0) begin errors++; $display("FAIL x1_de: %0d bad cycles want 0", cap_de); end
    checks++;
    if (cap_fs != 0) begin errors++; $display("FAIL x1_frame_start: %0d bad cycles want 0", cap_fs); end
  endtask

  task automatic test_scale2();
    set_frame(1'b1, 2'd1, 4, 2);
    capture(1'b0, 1'b0, 2'd0, 0);
    checks++;
    if (cap_reads != 32) begin errors++; $display("FAIL x2_reads: got %0d want 32", cap_reads); end
    checks++;
    if (cap_ph != 0) begin errors++; $display("FAIL x2_read_phase: %0d misplaced reads want 0", cap_ph); end
    checks++;
    if (cap_img != 0) begin
      errors++;
      $display("FAIL x2_image: %0d bad, first v=%0d h=%0d got %h want %h", cap_img, cap_ev, cap_eh, cap_ea, cap_ee);
    end
  endtask

  task automatic test_scale4();
    set_frame(1'b1, 2'd2, 4, 2);
    capture(1'b0, 1'b0, 2'd0, 0);
    checks++;
    if (cap_reads != 8) begin errors++; $display("FAIL x4_reads: got %0d want 8", cap_reads); end
    checks++;
    if (cap_ph != 0) begin errors++; $display("FAIL x4_read_phase: %0d misplaced reads want 0", cap_ph); end
    checks++;
    if (cap_img != 0) begin
      errors++;
      $display("FAIL x4_image: %0d bad, first v=%0d h=%0d got %h want %h", cap_img, cap_ev, cap_eh, cap_ea, cap_ee);
    end
  endtask

  task automatic test_scale3();
    set_frame(1'b1, 2'd3, 4, 2);
    capture(1'b0, 1'b0, 2'd0, 0);
    checks++;
    if (cap_reads != 8) begin errors++; $display("FAIL s3_reads: got %0d want 8", cap_reads); end
    checks++;
    if (cap_img != 0) begin
      errors++;
      $display("FAIL s3_image: %0d bad, first v=%0d h=%0d got %h want %h", cap_img, cap_ev, cap_eh, cap_ea, cap_ee);
    end
  endtask

  task automatic test_clamp();
    set_frame(1'b1, 2'd0, 30, 20);
    capture(1'b0, 1'b0, 2'd0, 0);
    checks++;
    if (cap_frv != 12 || cap_frh != 23) begin
      errors++; $display("FAIL clamp_first_req: v=%0d h=%0d want v=12 h=23", cap_frv, cap_frh);
    end
    checks++;
    if (cap_lgh != 40) begin errors++; $display("FAIL clamp_last_rgb: h=%0d want 40", cap_lgh); end
    checks++;
    if (cap_reads != 128) begin errors++; $display("FAIL clamp_reads: got %0d want 128", cap_reads); end
    checks++;
    if (cap_img != 0) begin
      errors++;
      $display("FAIL clamp_image: %0d bad, first v=%0d h=%0d got %h want %h", cap_img, cap_ev, cap_eh, cap_ea, cap_ee);
    end
  endtask

  task automatic test_midframe();
    set_frame(1'b1, 2'd0, 4, 2);
    capture(1'b0, 1'b1, 2'd2, 12);
    checks++;
    if (cap_reads != 128) begin errors++; $display("FAIL mid_old_reads: got %0d want 128", cap_reads); end
    checks++;
    if (cap_img != 0) begin
      errors++;
      $display("FAIL mid_old_image: %0d bad, first v=%0d h=%0d got %h want %h", cap_img, cap_ev, cap_eh, cap_ea, cap_ee);
    end
    set_frame(1'b1, 2'd2, 12, 2);
    capture(1'b0, 1'b0, 2'd0, 0);
    checks++;
    if (cap_reads != 8) begin errors++; $display("FAIL mid_new_reads: got %0d want 8", cap_reads); end
    checks++;
    if (cap_frh != 19) begin errors++; $display("FAIL mid_new_first_req: h=%0d want 19", cap_frh); end
    checks++;
    if (cap_img != 0) begin
      errors++;
      $display("FAIL mid_new_image: %0d bad, first v=%0d h=%0d got %h want %h", cap_img, cap_ev, cap_eh, cap_ea, cap_ee);
    end
  endtask

  task automatic test_disable();
    set_frame(1'b0, 2'd0, 4, 2);
    capture(1'b0, 1'b0, 2'd0, 0);
    checks++;
    if (cap_reads != 0) begin errors++; $display("FAIL dis_reads: got %0d want 0", cap_reads); end
    checks++;
    if (cap_fgv != -1) begin
      errors++; $display("FAIL dis_rgb: non-zero RGB at v=%0d h=%0d want none", cap_fgv, cap_fgh);
    end
    checks++;
    if (cap_decnt != HA * VA) begin errors++; $display("FAIL dis_de_count: got %0d want %0d", cap_decnt, HA * VA); end
    checks++;
    if (cap_de != 0) begin errors++; $display("FAIL dis_de: %0d bad cycles want 0", cap_de); end
  endtask

  task automatic test_reset_mid();
    int n;
    set_frame(1'b1, 2'd1, 4, 2);
    n = 0;
    while (!(tv == 8 && th == 20) && n < FRAME) begin @(negedge clk); n++; end
    checks++;
    if ({r_out, g_out, b_out} !== {10'd12, 10'd38, 10'd1012}) begin
      errors++; $display("FAIL pre_reset_pixel: rgb=%h want %h (wait %0d)", {r_out, g_out, b_out},
                         {10'd12, 10'd38, 10'd1012}, n);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({req, de, fs, r_out, g_out, b_out} !== 33'd0) begin
      errors++; $display("FAIL mid_reset_outputs: %h want 0", {req, de, fs, r_out, g_out, b_out});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    capture(1'b1, 1'b0, 2'd0, 0);
    checks++;
    if (cap_reads != 32) begin errors++; $display("FAIL post_reset_reads: got %0d want 32", cap_reads); end
    checks++;
    if (cap_img != 0) begin
      errors++;
      $display("FAIL post_reset_image: %0d bad, first v=%0d h=%0d got %h want %h", cap_img, cap_ev, cap_eh, cap_ea, cap_ee);
    end
    checks++;
    if (cap_fs != 0) begin errors++; $display("FAIL post_reset_frame_start: %0d bad cycles want 0", cap_fs); end
  endtask

  initial begin
    test_reset();
    test_scale1();
    test_scale2();
    test_scale4();
    test_scale3();
    test_clamp();
    test_midframe();
    test_disable();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
